// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU receive framer: buffers UART bytes, feeds an external CRC-16 engine, closes frames on T3.5 silence.
// Optional address filter enabled by defining MODBUS_ADDR_FILTER_EN.
module modbus_rtu_frame_rx #(
  parameter int          MAX_LEN    = 256,
  parameter logic [15:0] T35_CYCLES = 16'd1750,
  parameter int          AW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    crc_byte,
  output logic          crc_start,
  output logic          crc_reset,
  input  logic          crc_busy,
  input  logic [15:0]   crc_value,
  input  logic [7:0]    slave_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   frame_len,
  output logic          frame_ok,
  output logic          frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FEED, S_WAIT_HI, S_WAIT_LO, S_GAP, S_EVAL
  } state_t;

  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(4);

  state_t        state_q, state_d;
  logic          hold_full;
  logic [7:0]    hold_data;
  logic          ovr;
  logic [CW-1:0] wr_cnt;
  logic [15:0]   timer;
  logic [7:0]    byte0;
  logic [7:0]    mem [2**AW];

  logic          feeding;
  logic          drop;
  logic          frame_bad;
  logic          addr_skip;
  logic [CW-1:0] len_clamped;

  assign feeding   = (state_q == S_FEED);
  assign drop      = rx_valid && hold_full && !feeding;
  assign crc_byte  = hold_data;
  assign frame_bad = ovr || (wr_cnt < CNT_MIN) || (crc_value != 16'h0000);
  // The count runs one past MAX_LEN only to flag overrun; frame_len reports bytes actually held.
  assign len_clamped = (wr_cnt > CNT_MAX) ? CNT_MAX : wr_cnt;

`ifdef MODBUS_ADDR_FILTER_EN
  assign addr_skip = !frame_bad && (byte0 != slave_addr) && (byte0 != 8'h00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_addr, byte0};
  assign addr_skip        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output and next state gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    crc_start = 1'b0;
    crc_reset = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        crc_reset = 1'b1;
        if (hold_full) state_d = S_CLR;
      end
      S_CLR:     state_d = S_FEED;
      S_FEED: begin
        crc_start = 1'b1;
        state_d   = S_WAIT_HI;
      end
      S_WAIT_HI: if (crc_busy)  state_d = S_WAIT_LO;
      S_WAIT_LO: if (!crc_busy) state_d = S_GAP;
      S_GAP: begin
        if (hold_full)                 state_d = S_FEED;
        else if (timer >= T35_CYCLES)  state_d = S_EVAL;
      end
      S_EVAL:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; later statements in the block take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      ovr       <= 1'b0;
      wr_cnt    <= '0;
      timer     <= 16'h0000;
      byte0     <= 8'h00;
      rd_data   <= 8'h00;
      frame_len <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_data   <= mem[rd_addr];
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid)                 timer <= 16'h0000;
      else if (timer < T35_CYCLES)  timer <= timer + 16'd1;

      // A strobe in the cycle FEED frees the register is captured, so it stays full.
      if (rx_valid && (!hold_full || feeding)) begin
        hold_data <= rx_data;
        hold_full <= 1'b1;
      end else if (feeding) begin
        hold_full <= 1'b0;
      end

      if (state_q == S_IDLE && hold_full) begin
        wr_cnt <= '0;
        ovr    <= 1'b0;
      end

      if (feeding) begin
        if (wr_cnt == '0)      byte0  <= hold_data;
        if (wr_cnt >= CNT_MAX) ovr    <= 1'b1;
        if (wr_cnt != CNT_SAT) wr_cnt <= wr_cnt + 1'b1;
      end

      // A dropped byte marks the frame it arrives in, even during the IDLE clear.
      if (drop) ovr <= 1'b1;

      if (state_q == S_EVAL && !addr_skip) begin
        frame_len <= len_clamped;
        frame_ok  <= !frame_bad;
        frame_err <= frame_bad;
      end
    end
  end

  // NOTE: the frame buffer has no reset; its contents are only meaningful once a frame has been written.
  always_ff @(posedge clk) begin
    if (feeding && (wr_cnt < CNT_MAX)) mem[wr_cnt[AW-1:0]] <= hold_data;
  end

endmodule
